// File: rtl/data_mem_ctrl.sv
// Multi-cycle byte-addressed data memory for the MIPS datapath: lw/sw with a
// programmable wait latency and a busy/done/err handshake for stalling the PC.
module data_mem_ctrl #(
  parameter int unsigned LAT   = 2,
  parameter int unsigned DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, ERR} state_t;

  localparam logic [3:0] LAT_CNT = 4'(LAT);

  state_t      state;
  logic [3:0]  cnt;
  logic        op_write;
  logic [7:0]  a_q;
  logic [31:0] wdata_q;
  logic [7:0]  mem [DEPTH];

  logic        req;
  logic        illegal;
  logic        access;
  logic [7:0]  a1;
  logic [7:0]  a2;
  logic [7:0]  a3;
  logic        unused_addr_bits;

  assign req     = mem_read | mem_write;
  assign illegal = (addr[1:0] != 2'b00) | (mem_read & mem_write);
  assign access  = (state == WAIT) && (cnt == 4'd1);

  // The latched address is word aligned, so the byte lanes never carry into bit 2.
  assign a1 = {a_q[7:2], 2'b01};
  assign a2 = {a_q[7:2], 2'b10};
  assign a3 = {a_q[7:2], 2'b11};

  assign unused_addr_bits = ^addr[31:8];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      op_write <= 1'b0;
      a_q      <= 8'd0;
      wdata_q  <= 32'd0;
      rdata    <= 32'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            busy <= 1'b1;
            if (illegal) begin
              state <= ERR;
            end else begin
              state    <= WAIT;
              cnt      <= LAT_CNT;
              op_write <= mem_write;
              a_q      <= addr[7:0];
              wdata_q  <= wdata;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= DONE;
            done  <= 1'b1;
            if (!op_write) begin
              rdata <= {mem[a_q], mem[a1], mem[a2], mem[a3]};
            end
          end
        end
        // A rejected request spends one cycle here so its done/err pulse lands
        // one edge after acceptance, then shares the DONE exit with legal ops.
        ERR: begin
          state <= DONE;
          done  <= 1'b1;
          err   <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
        end
      endcase
    end
  end

  // Storage has no reset; a reset landing on the access edge must still block the store.
  always_ff @(posedge clk) begin
    if (!rst && access && op_write) begin
      mem[a_q] <= wdata_q[31:24];
      mem[a1]  <= wdata_q[23:16];
      mem[a2]  <= wdata_q[15:8];
      mem[a3]  <= wdata_q[7:0];
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl with LAT=2.
module tb_data_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  data_mem_ctrl #(.LAT(2), .DEPTH(256)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation hung");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [31:0] a, input logic [31:0] d);
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, drop it after acceptance and stop in the done cycle.
  task automatic run_op(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, output int lat);
    applyStimulus(rd, wr, a, d);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int period;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    tick();
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_err", {31'd0, err}, 32'd0);
    checkOutput("reset_rdata", rdata, 32'd0);
    rst = 1'b0;
    tick();

    // T1: store with cycle-by-cycle handshake
    applyStimulus(1'b0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("t1_busy_e0", {31'd0, busy}, 32'd1);
    checkOutput("t1_done_e0", {31'd0, done}, 32'd0);
    tick();
    checkOutput("t1_done_e1", {31'd0, done}, 32'd0);
    tick();
    checkOutput("t1_done_e2", {31'd0, done}, 32'd1);
    checkOutput("t1_err_e2", {31'd0, err}, 32'd0);
    checkOutput("t1_busy_e2", {31'd0, busy}, 32'd1);
    tick();
    checkOutput("t1_done_e3", {31'd0, done}, 32'd0);
    checkOutput("t1_busy_e3", {31'd0, busy}, 32'd0);
    checkOutput("t1_mem8", {24'd0, dut.mem[8]}, 32'h0000_00DE);
    checkOutput("t1_mem9", {24'd0, dut.mem[9]}, 32'h0000_00AD);
    checkOutput("t1_mem10", {24'd0, dut.mem[10]}, 32'h0000_00BE);
    checkOutput("t1_mem11", {24'd0, dut.mem[11]}, 32'h0000_00EF);

    // T2: load back, then a store must leave rdata alone
    run_op(1'b1, 1'b0, 32'h0000_0008, 32'd0, lat);
    checkOutput("t2_lat", lat, 32'd2);
    checkOutput("t2_rdata", rdata, 32'hDEAD_BEEF);
    tick();
    run_op(1'b0, 1'b1, 32'h0000_000C, 32'h1122_3344, lat);
    checkOutput("t2_store_lat", lat, 32'd2);
    tick();
    checkOutput("t2_rdata_hold", rdata, 32'hDEAD_BEEF);

    // Known contents for the reject and reset tests
    run_op(1'b0, 1'b1, 32'h0000_0010, 32'hA5A5_5A5A, lat);
    tick();
    run_op(1'b0, 1'b1, 32'h0000_0020, 32'h0BAD_F00D, lat);
    tick();

    // T3: misaligned load is rejected one edge after acceptance
    applyStimulus(1'b1, 1'b0, 32'h0000_0006, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("t3_busy_e0", {31'd0, busy}, 32'd1);
    checkOutput("t3_done_e0", {31'd0, done}, 32'd0);
    tick();
    checkOutput("t3_done_e1", {31'd0, done}, 32'd1);
    checkOutput("t3_err_e1", {31'd0, err}, 32'd1);
    checkOutput("t3_rdata", rdata, 32'hDEAD_BEEF);
    tick();
    checkOutput("t3_err_e2", {31'd0, err}, 32'd0);
    checkOutput("t3_busy_e2", {31'd0, busy}, 32'd0);

    // T4: simultaneous read and write is rejected, memory untouched
    run_op(1'b1, 1'b1, 32'h0000_0010, 32'hFFFF_FFFF, lat);
    checkOutput("t4_lat", lat, 32'd1);
    checkOutput("t4_err", {31'd0, err}, 32'd1);
    tick();
    run_op(1'b1, 1'b0, 32'h0000_0010, 32'd0, lat);
    checkOutput("t4_err_legal", {31'd0, err}, 32'd0);
    checkOutput("t4_mem_kept", rdata, 32'hA5A5_5A5A);
    tick();

    // T5: reset during WAIT cancels the store and clears rdata
    applyStimulus(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t5_busy", {31'd0, busy}, 32'd0);
    checkOutput("t5_rdata", rdata, 32'd0);
    // reset on the access edge itself
    applyStimulus(1'b0, 1'b1, 32'h0000_0020, 32'h5566_7788);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t5_edge_done", {31'd0, done}, 32'd0);
    run_op(1'b1, 1'b0, 32'h0000_0020, 32'd0, lat);
    checkOutput("t5_old_value", rdata, 32'h0BAD_F00D);
    tick();

    // T6: address aliasing modulo 256 and back-to-back held requests
    run_op(1'b0, 1'b1, 32'h0000_0104, 32'hCAFE_F00D, lat);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0000_0004, 32'd0);
    tick();
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    checkOutput("t6_lat", lat, 32'd2);
    checkOutput("t6_alias", rdata, 32'hCAFE_F00D);
    period = 0;
    do begin
      tick();
      period++;
    end while (!done && period < 20);
    checkOutput("t6_period", period, 32'd4);
    checkOutput("t6_alias_again", rdata, 32'hCAFE_F00D);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    checkOutput("t6_idle_busy", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
